// File: rtl/exe_operand_latch.sv
// Execution-unit input capture bank: latches decoded operands, opcode and
// destination on a single strobe, built from one generic enabled register cell.

module exe_operand_reg #(
  parameter int W = 32
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Enable,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  // Reset clears, enable loads, otherwise the cell keeps its contents.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Q <= {W{1'b0}};
    end else if (Enable) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule

module exe_operand_latch_chk #(
  parameter int WIDTH      = 32,
  parameter int OP_WIDTH   = 16,
  parameter int ADDR_WIDTH = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  input logic                  iLatch,
  input logic [3*WIDTH-1:0]    iSource0,
  input logic [3*WIDTH-1:0]    iSource1,
  input logic [OP_WIDTH-1:0]   iOperation,
  input logic [ADDR_WIDTH-1:0] iDestination,
  input logic [3*WIDTH-1:0]    row1_q,
  input logic [3*WIDTH-1:0]    row0_q,
  input logic [OP_WIDTH-1:0]   oALUOperation,
  input logic [ADDR_WIDTH-1:0] oDestination,
  input logic                  oCaptured
);

  a_reset_clears: assert property (@(posedge Clock)
    !Reset |=> (row1_q == {(3*WIDTH){1'b0}}) && (row0_q == {(3*WIDTH){1'b0}}) &&
               (oALUOperation == {OP_WIDTH{1'b0}}) &&
               (oDestination == {ADDR_WIDTH{1'b0}}) && !oCaptured);

  a_capture: assert property (@(posedge Clock)
    (Reset && iLatch) |=> oCaptured && (row1_q == $past(iSource1)) &&
                          (row0_q == $past(iSource0)) &&
                          (oALUOperation == $past(iOperation)) &&
                          (oDestination == $past(iDestination)));

  a_hold: assert property (@(posedge Clock)
    (Reset && !iLatch) |=> !oCaptured && $stable(row1_q) && $stable(row0_q) &&
                           $stable(oALUOperation) && $stable(oDestination));

endmodule

module exe_operand_latch #(
  parameter int WIDTH      = 32,
  parameter int OP_WIDTH   = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iLatch,
  input  logic [3*WIDTH-1:0]    iSource0,
  input  logic [3*WIDTH-1:0]    iSource1,
  input  logic [OP_WIDTH-1:0]   iOperation,
  input  logic [ADDR_WIDTH-1:0] iDestination,
  output logic [WIDTH-1:0]      oALUChannelX1,
  output logic [WIDTH-1:0]      oALUChannelY1,
  output logic [WIDTH-1:0]      oALUChannelZ1,
  output logic [WIDTH-1:0]      oALUChannelX2,
  output logic [WIDTH-1:0]      oALUChannelY2,
  output logic [WIDTH-1:0]      oALUChannelZ2,
  output logic [OP_WIDTH-1:0]   oALUOperation,
  output logic [ADDR_WIDTH-1:0] oDestination,
  output logic                  oCaptured
);

  // Row 1 feeds channel set 1, row 0 feeds channel set 2; X sits in the MSBs.
  exe_operand_reg #(.W(WIDTH)) u_x1 (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iSource1[3*WIDTH-1:2*WIDTH]), .Q(oALUChannelX1)
  );
  exe_operand_reg #(.W(WIDTH)) u_y1 (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iSource1[2*WIDTH-1:WIDTH]), .Q(oALUChannelY1)
  );
  exe_operand_reg #(.W(WIDTH)) u_z1 (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iSource1[WIDTH-1:0]), .Q(oALUChannelZ1)
  );
  exe_operand_reg #(.W(WIDTH)) u_x2 (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iSource0[3*WIDTH-1:2*WIDTH]), .Q(oALUChannelX2)
  );
  exe_operand_reg #(.W(WIDTH)) u_y2 (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iSource0[2*WIDTH-1:WIDTH]), .Q(oALUChannelY2)
  );
  exe_operand_reg #(.W(WIDTH)) u_z2 (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iSource0[WIDTH-1:0]), .Q(oALUChannelZ2)
  );

  exe_operand_reg #(.W(OP_WIDTH)) u_op (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iOperation), .Q(oALUOperation)
  );
  exe_operand_reg #(.W(ADDR_WIDTH)) u_dest (
    .Clock(Clock), .Reset(Reset), .Enable(iLatch),
    .D(iDestination), .Q(oDestination)
  );

  // Always-enabled cell turns the strobe into a pulse one cycle later.
  exe_operand_reg #(.W(1)) u_cap (
    .Clock(Clock), .Reset(Reset), .Enable(1'b1),
    .D(iLatch), .Q(oCaptured)
  );

  exe_operand_latch_chk #(
    .WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_chk (
    .Clock(Clock), .Reset(Reset), .iLatch(iLatch),
    .iSource0(iSource0), .iSource1(iSource1),
    .iOperation(iOperation), .iDestination(iDestination),
    .row1_q({oALUChannelX1, oALUChannelY1, oALUChannelZ1}),
    .row0_q({oALUChannelX2, oALUChannelY2, oALUChannelZ2}),
    .oALUOperation(oALUOperation), .oDestination(oDestination),
    .oCaptured(oCaptured)
  );

endmodule

// File: tb/tb_exe_operand_latch.sv
// Directed bench for exe_operand_latch: stimulus pushes the expected outputs
// for the following cycle into a queue, a monitor pops and compares them.

module tb_exe_operand_latch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iLatch = 1'b1;
  logic [95:0] iSource0 = 96'h01234567_89ABCDEF_0F0F0F0F;
  logic [95:0] iSource1 = 96'hDEADBEEF_CAFEF00D_12345678;
  logic [15:0] iOperation = 16'h1234;
  logic [15:0] iDestination = 16'h5678;
  logic [31:0] oALUChannelX1, oALUChannelY1, oALUChannelZ1;
  logic [31:0] oALUChannelX2, oALUChannelY2, oALUChannelZ2;
  logic [15:0] oALUOperation, oDestination;
  logic        oCaptured;

  typedef struct {
    logic [31:0] x1, y1, z1, x2, y2, z2;
    logic [15:0] op, dest;
    logic        cap;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  exe_operand_latch dut (
    .Clock(Clock), .Reset(Reset), .iLatch(iLatch),
    .iSource0(iSource0), .iSource1(iSource1),
    .iOperation(iOperation), .iDestination(iDestination),
    .oALUChannelX1(oALUChannelX1), .oALUChannelY1(oALUChannelY1),
    .oALUChannelZ1(oALUChannelZ1), .oALUChannelX2(oALUChannelX2),
    .oALUChannelY2(oALUChannelY2), .oALUChannelZ2(oALUChannelZ2),
    .oALUOperation(oALUOperation), .oDestination(oDestination),
    .oCaptured(oCaptured)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, push what the next rising edge must produce.
  task automatic step(input logic rst, input logic lat, input logic [95:0] s1,
                      input logic [95:0] s0, input logic [15:0] op, input logic [15:0] dest);
    @(negedge Clock);
    Reset = rst; iLatch = lat; iSource1 = s1; iSource0 = s0;
    iOperation = op; iDestination = dest;
    if (!rst) begin
      model = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b0};
    end else if (lat) begin
      model = '{s1[95:64], s1[63:32], s1[31:0], s0[95:64], s0[63:32], s0[31:0], op, dest, 1'b1};
    end else begin
      model.cap = 1'b0;
    end
    exp_q.push_back(model);
  endtask

  task automatic hold_random(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
           16'($urandom), 16'($urandom));
  endtask

  // Monitor: every cycle the DUT outputs are compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("x1", oALUChannelX1, e.x1);
        check("y1", oALUChannelY1, e.y1);
        check("z1", oALUChannelZ1, e.z1);
        check("x2", oALUChannelX2, e.x2);
        check("y2", oALUChannelY2, e.y2);
        check("z2", oALUChannelZ2, e.z2);
        check("op", 32'(oALUOperation), 32'(e.op));
        check("dest", 32'(oDestination), 32'(e.dest));
        check("captured", 32'(oCaptured), 32'(e.cap));
      end
    end
  end

  initial begin
    // Reset held with strobe and nonzero inputs.
    step(1'b0, 1'b1, 96'hDEADBEEF_CAFEF00D_12345678, 96'h01234567_89ABCDEF_0F0F0F0F, 16'h1234, 16'h5678);
    step(1'b0, 1'b1, 96'hDEADBEEF_CAFEF00D_12345678, 96'h01234567_89ABCDEF_0F0F0F0F, 16'h1234, 16'h5678);

    // Single capture, then five hold cycles with changing inputs.
    step(1'b1, 1'b1, 96'h11111111_22222222_33333333, 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 16'h0005, 16'h00F3);
    hold_random(5);

    // Back-to-back captures.
    step(1'b1, 1'b1, 96'h00000001_00000002_00000003, 96'h00000004_00000005_00000006, 16'h0001, 16'h0001);
    step(1'b1, 1'b1, 96'h10000001_20000002_30000003, 96'h40000004_50000005_60000006, 16'h0002, 16'h0002);
    step(1'b1, 1'b1, 96'h11000001_22000002_33000003, 96'h44000004_55000005_66000006, 16'h0003, 16'h0003);
    hold_random(1);

    // Capture, reset with strobe high, release with strobe high.
    step(1'b1, 1'b1, 96'h0A0A0A0A_0B0B0B0B_0C0C0C0C, 96'h0D0D0D0D_0E0E0E0E_0F0F0F0F, 16'h0042, 16'h00F3);
    hold_random(2);
    step(1'b0, 1'b1, 96'h99999999_88888888_77777777, 96'h66666666_55555555_44444444, 16'h0007, 16'h0077);
    step(1'b1, 1'b1, 96'h12121212_34343434_56565656, 96'h78787878_9A9A9A9A_BCBCBCBC, 16'h0009, 16'h0099);
    hold_random(1);

    // All ones, then reset clears every bit.
    step(1'b1, 1'b1, {3{32'hFFFFFFFF}}, {3{32'hFFFFFFFF}}, 16'hFFFF, 16'hFFFF);
    hold_random(1);
    step(1'b0, 1'b0, {3{32'hFFFFFFFF}}, {3{32'hFFFFFFFF}}, 16'hFFFF, 16'hFFFF);
    hold_random(1);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 1000) begin
      @(posedge Clock);
      budget++;
    end
    #2;
    total++;
    if (exp_q.size() != 0 || !stim_done) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_operand_latch.md
Name: exe_operand_latch

Overview:
- Input capture register bank for the execution unit.
- Captures the decoded instruction into registered ALU operand lanes, opcode and destination address on a single latch strobe.
- Operands are two 96-bit rows from decode; the opcode is the ALU operation; the destination is the RAM write-back address, also used as the jump target and the data-forward address.
- Built from one generic synchronous-reset enabled register cell, instantiated per field: six 32-bit lanes, one opcode register, one 16-bit destination register.

Parameters:
- WIDTH, 32, width of one operand lane.
- OP_WIDTH, 16, width of the opcode field.
- ADDR_WIDTH, 16, width of the destination address.

Ports:
- Clock  in  1  system clock, rising-edge active.
- Reset  in  1  synchronous, active-low reset.
- iLatch  in  1  capture strobe (decode done AND latches enabled).
- iSource0  in  3*WIDTH  operand row 0 {X,Y,Z}, X in the MSBs.
- iSource1  in  3*WIDTH  operand row 1 {X,Y,Z}, X in the MSBs.
- iOperation  in  OP_WIDTH  decoded opcode.
- iDestination  in  ADDR_WIDTH  decoded destination address.
- oALUChannelX1  out  WIDTH  iSource1[3W-1:2W], registered.
- oALUChannelY1  out  WIDTH  iSource1[2W-1:W], registered.
- oALUChannelZ1  out  WIDTH  iSource1[W-1:0], registered.
- oALUChannelX2  out  WIDTH  iSource0[3W-1:2W], registered.
- oALUChannelY2  out  WIDTH  iSource0[2W-1:W], registered.
- oALUChannelZ2  out  WIDTH  iSource0[W-1:0], registered.
- oALUOperation  out  OP_WIDTH  registered opcode.
- oDestination  out  ADDR_WIDTH  registered destination; also the write address, jump IP and last-destination forward.
- oCaptured  out  1  one-cycle pulse, high in the cycle after a capture.

Behaviour:
- All state updates only on the rising edge of Clock; no gated or derived clocks.
- Reset low at an edge:
  - every Q output cleared to 0: all six lanes, opcode, destination and oCaptured.
  - Reset has priority over iLatch.
- Reset high and iLatch high at an edge: every register loads its slice of the inputs simultaneously; oCaptured = 1 next cycle.
- Reset high and iLatch low: all registers hold; oCaptured = 0.
- Latency: inputs sampled at edge N appear on the outputs after edge N (visible in cycle N+1). No combinational path from D to Q.
- Back-to-back iLatch: each edge captures fresh values; oCaptured stays high continuously.
- Reset asserted mid-hold (after a capture): outputs return to 0 at that edge; earlier values are lost.
- Reset released with iLatch high at the same edge: that edge still resets; capture occurs at the next edge only.
- Inputs may be X/changing when iLatch is low; outputs must remain unaffected.
- Lane mapping is fixed:
  - row 1 drives channel set 1, row 0 drives channel set 2.
  - bits [95:64] go to X, [63:32] to Y, [31:0] to Z (for WIDTH=32).
- Register cell (generic, width-parameterized): D, Q, Clock, Reset, Enable; Q <= 0 on reset, D on enable, else hold.
- Power-up contents are undefined until the first reset edge.

Test Plan:
- Hold Reset=0 for 2 edges with iLatch=1 and nonzero inputs → all outputs 0 and oCaptured=0.
- Reset=1, iLatch pulsed 1 cycle with iSource1=96'h11111111_22222222_33333333, iSource0=96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, iOperation=16'h0005, iDestination=16'h00F3 → next cycle:
  - X1=11111111, Y1=22222222, Z1=33333333
  - X2=AAAAAAAA, Y2=BBBBBBBB, Z2=CCCCCCCC
  - op=0005, dest=00F3, oCaptured=1 for exactly 1 cycle.
- After that capture, change all inputs for 5 cycles with iLatch=0 → outputs unchanged at the captured values, oCaptured=0.
- iLatch high on 3 consecutive edges with iDestination = 1, 2, 3 → oDestination follows 1, 2, 3 one cycle later each; oCaptured high for 3 cycles.
- Capture value 00F3, then Reset=0 and iLatch=1 at the same edge → all outputs 0; release Reset with iLatch=1 → capture at the following edge.
- Capture 96'hFFFF…F into both rows with op=FFFF → all lanes FFFFFFFF, op FFFF; next reset → all 0 (no stuck bits).
